madd_accum: RTL and testbench

- Stage directly downstream of the pipelined multiply-add block.
- Consumes its `s` result stream and accumulates ACC_LEN consecutive valid results into one dot-product sum.
- Presents each sum on a single-entry valid/ready output register.
- The multiply-add block carries no valid signal, so this block delays the operand-launch valid by the multiply-add latency to align it with `s`.

---
 rtl/madd_pkg.sv | 14 +
 rtl/valid_delay.sv | 33 +++
 rtl/madd_accum.sv | 118 +++++++++++
 tb/tb_madd_accum.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/madd_pkg.sv
// Shared constants and helpers for the multiply-add accumulator slice.
package madd_pkg;

  localparam int unsigned MADD_LAT_DEF = 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  // Sum width that cannot wrap for acc_len samples of a 2*width-bit product.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned acc_len);
    return 2 * width + $clog2(acc_len);
  endfunction

endpackage

// File: rtl/valid_delay.sv
// Fixed-latency valid shift register with synchronous flush, used to track a
// datapath that carries no valid of its own.
module valid_delay #(
  parameter int unsigned DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_flush,
  input  logic i_valid,
  output logic o_valid
);

  logic [DEPTH-1:0] r_shift;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_shift <= '0;
        else if (i_flush) r_shift <= '0;
        else              r_shift <= i_valid;
      end
    end else begin : g_multi
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_shift <= '0;
        else if (i_flush) r_shift <= '0;
        else              r_shift <= {r_shift[DEPTH-2:0], i_valid};
      end
    end
  endgenerate

  assign o_valid = r_shift[DEPTH-1];

endmodule

// File: rtl/madd_accum.sv
// Accumulates ACC_LEN aligned multiply-add results into one sum, presented on a
// single-entry valid/ready register with a sticky overrun flag.
module madd_accum
  import madd_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned ACC_LEN  = 4,
  parameter int unsigned MADD_LAT = MADD_LAT_DEF,
  localparam int unsigned ACC_W   = acc_width(WIDTH, ACC_LEN)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_in_valid,
  input  logic [2*WIDTH-1:0] i_s_in,
  input  logic               i_clear,
  output logic [ACC_W-1:0]   o_out_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic               o_overrun
);

  localparam int unsigned CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  logic             w_s_vld;
  logic [ACC_W-1:0] w_s_ext;
  logic [ACC_W-1:0] w_sum;
  logic             w_complete;

  logic [0:0]       r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [ACC_W-1:0] r_acc, w_acc_d;
  logic [ACC_W-1:0] r_out_data, w_out_data_d;
  logic             r_out_valid, w_out_valid_d;
  logic             r_overrun, w_overrun_d;

  valid_delay #(
    .DEPTH (MADD_LAT)
  ) u_valid_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_clear),
    .i_valid (i_in_valid),
    .o_valid (w_s_vld)
  );

  assign w_s_ext = ACC_W'(i_s_in);

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_acc_d    = r_acc;
    w_sum      = w_s_ext;
    w_complete = 1'b0;
    if (i_clear) begin
      w_state_d = S_IDLE;
      w_cnt_d   = '0;
      w_acc_d   = '0;
    end else if (w_s_vld) begin
      if (r_state == S_IDLE) begin
        if (ACC_LEN == 1) begin
          w_complete = 1'b1;
        end else begin
          w_acc_d   = w_s_ext;
          w_cnt_d   = CNT_W'(1);
          w_state_d = S_ACC;
        end
      end else begin
        w_sum = r_acc + w_s_ext;
        if (r_cnt == CNT_LAST) begin
          w_complete = 1'b1;
          w_cnt_d    = '0;
          w_state_d  = S_IDLE;
        end else begin
          w_acc_d = w_sum;
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // A completion wins over a same-edge consume, so the register stays full.
  always_comb begin
    w_out_data_d  = r_out_data;
    w_out_valid_d = r_out_valid;
    w_overrun_d   = i_clear ? 1'b0 : r_overrun;
    if (w_complete) begin
      w_out_data_d  = w_sum;
      w_out_valid_d = 1'b1;
      if (r_out_valid && !i_out_ready) w_overrun_d = 1'b1;
    end else if (r_out_valid && i_out_ready) begin
      w_out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_acc       <= w_acc_d;
      r_out_data  <= w_out_data_d;
      r_out_valid <= w_out_valid_d;
      r_overrun   <= w_overrun_d;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_madd_accum.sv
// Bench for madd_accum: models the upstream multiply-add as a queue of timed
// results and the accumulator as frames of ACC_LEN arrivals.
module tb_madd_accum;

  localparam int WIDTH   = 3;
  localparam int ACC_LEN = 4;
  localparam int LAT     = 2;
  localparam int ACC_W   = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic [2*WIDTH-1:0] s_in = '0;
  logic               clear = 1'b0;
  logic               out_ready = 1'b0;
  logic [ACC_W-1:0]   out_data;
  logic               out_valid;
  logic               overrun;

  madd_accum #(
    .WIDTH    (WIDTH),
    .ACC_LEN  (ACC_LEN),
    .MADD_LAT (LAT)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .i_s_in      (s_in),
    .i_clear     (clear),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
  } launch_t;

  launch_t pipe_q[$];
  int      frame_q[$];
  int      exp_data;
  int      exp_valid;
  int      exp_overrun;
  int      cyc;
  int      n_checks;
  int      n_errors;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input bit iv, input int a, input int b, input int c,
                      input bit clr, input bit rdy);
    launch_t l;
    bit      done;
    bit      hs;
    int      sum;
    in_valid  = iv;
    clear     = clr;
    out_ready = rdy;
    if (pipe_q.size() > 0 && pipe_q[0].due == cyc) s_in = 6'(pipe_q[0].val);
    else s_in = 6'($urandom);
    if (iv) begin
      l.due = cyc + LAT;
      l.val = a * b + c;
      pipe_q.push_back(l);
    end
    @(posedge clk);
    hs   = (exp_valid != 0) && rdy;
    done = 1'b0;
    sum  = 0;
    if (clr) begin
      pipe_q.delete();
      frame_q.delete();
      exp_overrun = 0;
    end else if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
      frame_q.push_back(pipe_q[0].val);
      void'(pipe_q.pop_front());
      if (frame_q.size() == ACC_LEN) begin
        foreach (frame_q[i]) sum += frame_q[i];
        frame_q.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (exp_valid != 0 && !rdy) exp_overrun = 1;
      exp_data  = sum;
      exp_valid = 1;
    end else if (hs) begin
      exp_valid = 0;
    end
    cyc++;
    #1;
    check_eq("out_valid", int'(out_valid), exp_valid);
    check_eq("overrun", int'(overrun), exp_overrun);
    if (exp_valid != 0) check_eq("out_data", int'(out_data), exp_data);
  endtask

  task automatic launch(input int s, input bit rdy);
    step(1'b1, 0, 0, s, 1'b0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, rdy);
  endtask

  task automatic frame4(input int v0, input int v1, input int v2, input int v3,
                        input bit rdy);
    launch(v0, rdy);
    launch(v1, rdy);
    launch(v2, rdy);
    launch(v3, rdy);
  endtask

  initial begin
    bit gap_pat [9];
    int gap_val [9];
    int k;
    n_checks    = 0;
    n_errors    = 0;
    cyc         = 0;
    exp_data    = 0;
    exp_valid   = 0;
    exp_overrun = 0;

    #12;
    check_eq("reset_data", int'(out_data), 0);
    check_eq("reset_valid", int'(out_valid), 0);
    check_eq("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;

    // Full-scale frame: 4 x (7*7+7)
    for (int i = 0; i < 4; i++) step(1'b1, 7, 7, 7, 1'b0, 1'b1);
    idle(2, 1'b1);
    check_eq("full_valid", int'(out_valid), 1);
    check_eq("full_data", int'(out_data), 224);
    check_eq("full_overrun", int'(overrun), 0);
    idle(1, 1'b1);
    check_eq("full_consumed", int'(out_valid), 0);

    // Gapped frame: arrivals 1,2,3,4 launched at edges 0,2,5,6
    gap_pat = '{1, 0, 1, 0, 0, 1, 1, 0, 0};
    k = 1;
    for (int i = 0; i < 9; i++) begin
      gap_val[i] = gap_pat[i] ? k : 0;
      if (gap_pat[i]) k++;
    end
    for (int i = 0; i < 9; i++) begin
      if (i < 8) check_eq("gap_no_early", int'(out_valid), 0);
      step(gap_pat[i], 0, 0, gap_val[i], 1'b0, 1'b0);
    end
    check_eq("gap_valid", int'(out_valid), 1);
    check_eq("gap_data", int'(out_data), 10);
    idle(1, 1'b1);

    // Back-pressure: two sums with no consumer
    frame4(1, 2, 3, 4, 1'b0);
    idle(2, 1'b0);
    check_eq("bp_first", int'(out_data), 10);
    frame4(5, 5, 5, 5, 1'b0);
    idle(2, 1'b0);
    check_eq("bp_second", int'(out_data), 20);
    check_eq("bp_overrun", int'(overrun), 1);
    check_eq("bp_valid", int'(out_valid), 1);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    check_eq("bp_clr_overrun", int'(overrun), 0);
    check_eq("bp_clr_valid", int'(out_valid), 1);
    idle(1, 1'b1);

    // Consume and complete on the same edge
    frame4(1, 2, 3, 4, 1'b0);
    idle(2, 1'b0);
    frame4(5, 5, 5, 5, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    check_eq("sim_data", int'(out_data), 20);
    check_eq("sim_valid", int'(out_valid), 1);
    check_eq("sim_overrun", int'(overrun), 0);
    idle(1, 1'b1);

    // Clear mid-frame
    launch(5, 1'b0);
    launch(6, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    frame4(1, 1, 1, 1, 1'b0);
    idle(2, 1'b0);
    check_eq("clr_data", int'(out_data), 4);
    check_eq("clr_valid", int'(out_valid), 1);
    idle(1, 1'b1);

    // Asynchronous reset between edges, mid-frame with stale data held
    launch(2, 1'b0);
    launch(2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_data", int'(out_data), 0);
    check_eq("arst_valid", int'(out_valid), 0);
    check_eq("arst_overrun", int'(overrun), 0);
    pipe_q.delete();
    frame_q.delete();
    exp_data    = 0;
    exp_valid   = 0;
    exp_overrun = 0;
    #2;
    rst_n = 1'b1;
    frame4(2, 2, 2, 2, 1'b0);
    idle(2, 1'b0);
    check_eq("arst_after_data", int'(out_data), 8);
    check_eq("arst_after_valid", int'(out_valid), 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, int'($urandom % 8), int'($urandom % 8), int'($urandom % 8),
           ($urandom % 40) == 0, ($urandom % 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
